// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with registered
// sync, blanking and start-of-line/frame strobes aligned to the presented position.
module vga_timing_gen #(
   parameter int H_DISPLAY       = 640,
   parameter int H_FRONT         = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BACK          = 48,
   parameter int V_DISPLAY       = 480,
   parameter int V_BOTTOM        = 10,
   parameter int V_SYNC          = 2,
   parameter int V_TOP           = 33,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic [9:0] hpos,
   output logic [9:0] vpos,
   output logic       line_start,
   output logic       frame_start,
   output logic [9:0] frame_count
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
   localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
   localparam logic [10:0] HS_FIRST = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] HS_LAST  = 11'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [10:0] VS_FIRST = 11'(V_DISPLAY + V_BOTTOM);
   localparam logic [10:0] VS_LAST  = 11'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

   localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
   localparam logic SYNC_OFF = ~SYNC_ON;

   // ST_RESTART holds the raster at (0,0) for the first clock after reset so
   // that position is presented with its strobes and is not counted as a frame.
   typedef enum logic {ST_RESTART, ST_RUN} state_t;

   state_t     state;
   state_t     state_next;
   logic [9:0] h_next;
   logic [9:0] v_next;
   logic [9:0] fc_next;
   logic       hsync_next;
   logic       vsync_next;
   logic       display_next;
   logic       line_start_next;
   logic       frame_start_next;

   always_comb begin
      state_next = state;
      h_next     = hpos;
      v_next     = vpos;
      fc_next    = frame_count;
      unique case (state)
         ST_RESTART: begin
            h_next     = 10'd0;
            v_next     = 10'd0;
            state_next = ST_RUN;
         end
         ST_RUN: begin
            if (hpos == H_LAST) begin
               h_next = 10'd0;
               if (vpos == V_LAST) begin
                  v_next  = 10'd0;
                  fc_next = frame_count + 10'd1;
               end else begin
                  v_next = vpos + 10'd1;
               end
            end else begin
               h_next = hpos + 10'd1;
            end
         end
         default: state_next = ST_RESTART;
      endcase

      hsync_next       = (({1'b0, h_next} >= HS_FIRST) && ({1'b0, h_next} <= HS_LAST)) ? SYNC_ON : SYNC_OFF;
      vsync_next       = (({1'b0, v_next} >= VS_FIRST) && ({1'b0, v_next} <= VS_LAST)) ? SYNC_ON : SYNC_OFF;
      display_next     = ({1'b0, h_next} < H_VIS) && ({1'b0, v_next} < V_VIS);
      line_start_next  = (h_next == 10'd0);
      frame_start_next = (h_next == 10'd0) && (v_next == 10'd0);
   end

   // Decorations are registered from the next-state position so they line up
   // with hpos/vpos in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_RESTART;
         hpos        <= 10'd0;
         vpos        <= 10'd0;
         frame_count <= 10'd0;
         hsync       <= SYNC_OFF;
         vsync       <= SYNC_OFF;
         display_on  <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_next;
         hpos        <= h_next;
         vpos        <= v_next;
         frame_count <= fc_next;
         hsync       <= hsync_next;
         vsync       <= vsync_next;
         display_on  <= display_next;
         line_start  <= line_start_next;
         frame_start <= frame_start_next;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a full-size active-low instance and a tiny
// 8x4 active-high instance, both checked every cycle against a reference model.
module tb_vga_timing_gen;

   typedef struct {
      int h;
      int v;
      int fc;
      bit inRst;
   } model_t;

   logic clock = 1'b0;
   logic resetA = 1'b1;
   logic resetB = 1'b1;

   logic       hsyncA, vsyncA, displayA, lineA, frameA;
   logic [9:0] hposA, vposA, fcA;
   logic       hsyncB, vsyncB, displayB, lineB, frameB;
   logic [9:0] hposB, vposB, fcB;

   int compared = 0;
   int mismatched = 0;
   int cycle = 0;

   model_t mA;
   model_t mB;
   logic [34:0] qA[$];
   logic [34:0] qB[$];

   int  lineCountA = 0;
   int  hsyncCountA = 0;
   int  prevFcB = 0;
   bit  sawWrapB = 0;
   bit  sawOneB = 0;

   always #5 clock = ~clock;

   vga_timing_gen dutA (
      .clk(clock), .reset(resetA),
      .hsync(hsyncA), .vsync(vsyncA), .display_on(displayA),
      .hpos(hposA), .vpos(vposA), .line_start(lineA),
      .frame_start(frameA), .frame_count(fcA)
   );

   vga_timing_gen #(
      .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_DISPLAY(2), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(0),
      .SYNC_ACTIVE_LOW(0)
   ) dutB (
      .clk(clock), .reset(resetB),
      .hsync(hsyncB), .vsync(vsyncB), .display_on(displayB),
      .hpos(hposB), .vpos(vposB), .line_start(lineB),
      .frame_start(frameB), .frame_count(fcB)
   );

   function automatic model_t stepModel(model_t m, bit r, int hTotal, int vTotal);
      model_t n;
      n = m;
      if (r) begin
         n.h = 0; n.v = 0; n.fc = 0; n.inRst = 1'b1;
      end else if (m.inRst) begin
         n.h = 0; n.v = 0; n.inRst = 1'b0;
      end else begin
         n.h = m.h + 1;
         if (n.h == hTotal) begin
            n.h = 0;
            n.v = m.v + 1;
            if (n.v == vTotal) begin
               n.v = 0;
               n.fc = (m.fc + 1) % 1024;
            end
         end
      end
      return n;
   endfunction

   function automatic logic [34:0] expectOut(model_t m, int hd, int hf, int hs,
                                             int vd, int vb, int vs, bit activeLow);
      logic hAct, vAct, disp, ls, fs;
      if (m.inRst)
         return {activeLow, activeLow, 3'b000, 10'd0, 10'd0, 10'd0};
      hAct = (m.h >= hd + hf) && (m.h <= hd + hf + hs - 1);
      vAct = (m.v >= vd + vb) && (m.v <= vd + vb + vs - 1);
      disp = (m.h < hd) && (m.v < vd);
      ls   = (m.h == 0);
      fs   = (m.h == 0) && (m.v == 0);
      return {hAct ^ activeLow, vAct ^ activeLow, disp, ls, fs,
              10'(m.h), 10'(m.v), 10'(m.fc)};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cycle, got, exp);
      end
   endtask

   // Drive the resets for the coming edge and record what each DUT must show after it.
   task automatic applyStimulus(input bit rA, input bit rB);
      @(negedge clock);
      resetA = rA;
      resetB = rB;
      mA = stepModel(mA, rA, 800, 525);
      mB = stepModel(mB, rB, 8, 4);
      qA.push_back(expectOut(mA, 640, 16, 96, 480, 10, 2, 1'b1));
      qB.push_back(expectOut(mB, 4, 1, 2, 2, 1, 1, 1'b0));
   endtask

   task automatic sampleCycle();
      logic [34:0] expA, expB;
      @(posedge clock);
      #1;
      if (qA.size() == 0 || qB.size() == 0) begin
         checkOutput("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         expA = qA.pop_front();
         expB = qB.pop_front();
         checkOutput("dutA_outputs",
                     {hsyncA, vsyncA, displayA, lineA, frameA, hposA, vposA, fcA}, expA);
         checkOutput("dutB_outputs",
                     {hsyncB, vsyncB, displayB, lineB, frameB, hposB, vposB, fcB}, expB);
      end
      if (cycle >= 3 && cycle <= 803) begin
         if (lineA === 1'b1) lineCountA++;
      end
      if (cycle >= 3 && cycle <= 802) begin
         if (hsyncA === 1'b0) hsyncCountA++;
      end
      if (prevFcB == 1023 && fcB == 10'd0) sawWrapB = 1'b1;
      if (sawWrapB && prevFcB == 0 && fcB == 10'd1) sawOneB = 1'b1;
      prevFcB = int'(fcB);
   endtask

   initial begin
      bit rA, rB, doneA, doneB;
      mA = '{h: 0, v: 0, fc: 0, inRst: 1'b1};
      mB = '{h: 0, v: 0, fc: 0, inRst: 1'b1};
      doneA = 1'b0;
      doneB = 1'b0;
      $display("[TB] starting vga_timing_gen bench");
      for (int i = 0; i < 34000; i++) begin
         cycle = i;
         rA = (i < 3);
         rB = (i < 3);
         if (!doneA && !mA.inRst && mA.h == 300 && mA.v == 1) begin
            rA = 1'b1;
            doneA = 1'b1;
         end
         if (!doneB && !mB.inRst && mB.h == 3 && mB.v == 2 && mB.fc == 5) begin
            rB = 1'b1;
            doneB = 1'b1;
         end
         applyStimulus(rA, rB);
         sampleCycle();
      end
      checkOutput("dutA_line_start_count", 64'(lineCountA), 64'd2);
      checkOutput("dutA_hsync_width", 64'(hsyncCountA), 64'd96);
      checkOutput("dutA_mid_reset_hit", 64'(doneA), 64'd1);
      checkOutput("dutB_mid_reset_hit", 64'(doneB), 64'd1);
      checkOutput("dutB_frame_count_wrap", 64'(sawOneB), 64'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
